// File: rtl/pipe_ctrl.sv
// Hazard/stall controller: operand interlock, mult/div busy tracking, exception priority.
// Optional stall-cycle counter built only with PIPE_CTRL_STALL_CNT_EN defined.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_wa,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        D_md,
  input  logic        E_md_start,
  input  logic        E_is_div,
  input  logic        Req,
  output logic        PC_WrEn,
  output logic        FD_WrEn,
  output logic        DE_Stall,
  output logic        Req_all,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       hazard_rs;
  logic       hazard_rt;
  logic       md_hazard;
  logic       stall;

  always_comb begin
    hazard_rs = (D_rs_addr != 5'd0) &&
                (((E_wa == D_rs_addr) && (D_Tuse_rs < E_Tnew)) ||
                 ((M_wa == D_rs_addr) && (D_Tuse_rs < M_Tnew)));
    hazard_rt = (D_rt_addr != 5'd0) &&
                (((E_wa == D_rt_addr) && (D_Tuse_rt < E_Tnew)) ||
                 ((M_wa == D_rt_addr) && (D_Tuse_rt < M_Tnew)));
    md_hazard = D_md && (md_busy || E_md_start);
    // An exception flush always wins over any interlock.
    stall     = (hazard_rs || hazard_rt || md_hazard) && !Req;
  end

  assign PC_WrEn  = ~stall;
  assign FD_WrEn  = ~stall;
  assign DE_Stall = stall;
  assign Req_all  = Req;
  assign md_busy  = (state == BUSY);

  // cnt counts down to 0 inclusive, so busy lasts cnt_load+1 cycles (5 mult, 10 div).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (E_md_start && !Req) begin
            cnt   <= E_is_div ? 4'd9 : 4'd4;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + randomized bench for pipe_ctrl against a cycle-count reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_md, E_md_start, E_is_div, Req;
  logic        PC_WrEn, FD_WrEn, DE_Stall, Req_all, md_busy;
  logic [31:0] stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: remaining busy cycles and stall tally.
  int          busy_left = 0;
  logic [31:0] sc_model  = 32'd0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .E_wa(E_wa), .M_wa(M_wa), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .D_md(D_md), .E_md_start(E_md_start), .E_is_div(E_is_div), .Req(Req),
    .PC_WrEn(PC_WrEn), .FD_WrEn(FD_WrEn), .DE_Stall(DE_Stall),
    .Req_all(Req_all), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit reg_hz(input logic [4:0] a, input logic [1:0] tuse);
    int ta = tuse;
    bit from_e = (E_wa == a) && (ta < int'(E_Tnew));
    bit from_m = (M_wa == a) && (ta < int'(M_Tnew));
    return (a != 0) && (from_e || from_m);
  endfunction

  function automatic bit exp_stall();
    bit md = D_md && ((busy_left > 0) || E_md_start);
    return (reg_hz(D_rs_addr, D_Tuse_rs) || reg_hz(D_rt_addr, D_Tuse_rt) || md) && !Req;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit s = exp_stall();
    chk({tag, ".pc_wren"},  {31'd0, PC_WrEn},  {31'd0, ~s});
    chk({tag, ".fd_wren"},  {31'd0, FD_WrEn},  {31'd0, ~s});
    chk({tag, ".de_stall"}, {31'd0, DE_Stall}, {31'd0, s});
    chk({tag, ".req_all"},  {31'd0, Req_all},  {31'd0, Req});
    chk({tag, ".md_busy"},  {31'd0, md_busy},  {31'd0, busy_left > 0});
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, sc_model);
`else
    chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
`endif
  endtask

  // Check current cycle, advance model across the edge, land 2 time units after it.
  task automatic cyc(input string tag);
    bit s;
    #1;
    if (reset) begin busy_left = 0; sc_model = 32'd0; end
    check_all(tag);
    s = exp_stall();
    if (!reset) begin
      if (s) sc_model = sc_model + 32'd1;
      if (busy_left > 0) busy_left--;
      else if (E_md_start && !Req) busy_left = E_is_div ? 10 : 5;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs_addr = 0; D_rt_addr = 0; D_Tuse_rs = 3; D_Tuse_rt = 3;
    E_wa = 0; M_wa = 0; E_Tnew = 0; M_Tnew = 0;
    D_md = 0; E_md_start = 0; E_is_div = 0; Req = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    cyc("reset_state");
    cyc("reset_hold");
    reset = 1'b0;
    cyc("post_reset");

    // rs hazard on E, then Tuse catches up
    E_wa = 5; E_Tnew = 2; D_rs_addr = 5; D_Tuse_rs = 1;
    cyc("rs_hazard_e");
    chk("rs_hazard_e.direct", {31'd0, DE_Stall}, 32'd1);
    D_Tuse_rs = 2;
    cyc("rs_hazard_clear");
    // rt hazard via M
    idle_inputs(); M_wa = 7; M_Tnew = 1; D_rt_addr = 7; D_Tuse_rt = 0;
    cyc("rt_hazard_m");
    // register 0 exempt
    idle_inputs(); E_Tnew = 2; D_Tuse_rs = 0;
    cyc("r0_exempt");

    // mult: 5 busy cycles, D_md held stalls start + 5
    idle_inputs(); D_md = 1; E_md_start = 1;
    cyc("mult_start");
    E_md_start = 0;
    for (int i = 0; i < 6; i++) cyc($sformatf("mult_busy%0d", i + 1));
    chk("mult_done.direct", {31'd0, md_busy}, 32'd0);

    // div with a restart attempt at busy cycle 3
    idle_inputs(); E_md_start = 1; E_is_div = 1;
    cyc("div_start");
    E_md_start = 0; E_is_div = 0;
    for (int i = 1; i <= 11; i++) begin
      E_md_start = (i == 3);
      cyc($sformatf("div_busy%0d", i));
    end

    // start cancelled by Req; Req overrides hazard
    idle_inputs(); E_md_start = 1; Req = 1;
    cyc("start_with_req");
    idle_inputs(); Req = 1; E_wa = 5; E_Tnew = 2; D_rs_addr = 5; D_Tuse_rs = 0;
    cyc("req_over_hazard");
    chk("req_over_hazard.direct", {31'd0, DE_Stall}, 32'd0);

    // reset mid-div at busy cycle 4
    idle_inputs(); E_md_start = 1; E_is_div = 1;
    cyc("div2_start");
    idle_inputs();
    for (int i = 1; i <= 3; i++) cyc($sformatf("div2_busy%0d", i));
    chk("div2_busy4", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("div2_reset_async", {31'd0, md_busy}, 32'd0);
    cyc("div2_in_reset");
    reset = 1'b0;
    cyc("div2_after_reset");

    // 7 stall cycles, then reset clears the tally
    E_wa = 9; E_Tnew = 3; D_rt_addr = 9; D_Tuse_rt = 0;
    for (int i = 0; i < 7; i++) cyc($sformatf("stall7_%0d", i));
    idle_inputs();
    cyc("stall7_end");
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("stall7.count", stall_cnt, 32'd7);
`endif
    reset = 1'b1;
    #1;
    chk("stall7.reset", stall_cnt, 32'd0);
    cyc("stall7_in_reset");
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      D_rs_addr  = 5'($urandom_range(0, 3));
      D_rt_addr  = 5'($urandom_range(0, 3));
      E_wa       = 5'($urandom_range(0, 3));
      M_wa       = 5'($urandom_range(0, 3));
      D_Tuse_rs  = 2'($urandom_range(0, 3));
      D_Tuse_rt  = 2'($urandom_range(0, 3));
      E_Tnew     = 2'($urandom_range(0, 3));
      M_Tnew     = 2'($urandom_range(0, 3));
      D_md       = 1'($urandom_range(0, 1));
      E_md_start = ($urandom_range(0, 3) == 0);
      E_is_div   = 1'($urandom_range(0, 1));
      Req        = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      cyc($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
